// File: rtl/yadmc_pkg.sv
// Shared definitions for the yadmc command scheduler: FSM encoding and
// the width of the outstanding-refresh counter.
package yadmc_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StRefresh = 2'd2
  } state_e;

  localparam int unsigned PendW = 3;

endpackage

// File: rtl/yadmc_rr_pick.sv
// Combinational round-robin picker: selects the first requester at or after
// the pointer, wrapping, and reports it one-hot and as an index.
module yadmc_rr_pick #(
  parameter int unsigned NMasters = 4,
  parameter int unsigned IdxW     = $clog2(NMasters)
) (
  input  logic [NMasters-1:0] req_i,
  input  logic [IdxW-1:0]     ptr_i,
  output logic [NMasters-1:0] gnt_o,
  output logic [IdxW-1:0]     idx_o,
  output logic                valid_o
);

  logic [IdxW:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NMasters; i++) begin
      // ptr_i < NMasters, so a single conditional subtract is a full modulo
      cand = {1'b0, ptr_i} + (IdxW + 1)'(i);
      if (cand >= (IdxW + 1)'(NMasters)) begin
        cand = cand - (IdxW + 1)'(NMasters);
      end
      if (!valid_o && req_i[cand[IdxW-1:0]]) begin
        valid_o                 = 1'b1;
        idx_o                   = cand[IdxW-1:0];
        gnt_o[cand[IdxW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/yadmc_sched.sv
// Round-robin command scheduler sharing the SDRAM sequencer between masters,
// with postponable periodic auto-refresh forced once MAX_POSTPONE are owed.
module yadmc_sched
  import yadmc_pkg::*;
#(
  parameter int unsigned NMASTERS     = 4,
  parameter int unsigned TREFI_W      = 12,
  parameter int unsigned MAX_POSTPONE = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [TREFI_W-1:0]  trefi_i,
  input  logic [NMASTERS-1:0] req_i,
  output logic [NMASTERS-1:0] grant_o,
  output logic                refresh_o,
  input  logic                done_i,
  output logic [PendW-1:0]    pending_o
);

  localparam int unsigned IdxW = $clog2(NMASTERS);
  localparam logic [PendW-1:0] PendMax = PendW'(MAX_POSTPONE);

  state_e              state_q;
  logic [NMASTERS-1:0] grant_q;
  logic                refresh_q;
  logic [IdxW-1:0]     ptr_q;
  logic [IdxW-1:0]     gidx_q;
  logic [TREFI_W-1:0]  tcnt_q;
  logic [PendW-1:0]    pending_q, pending_d;

  logic                tick;
  logic                refr_done;
  logic [NMASTERS-1:0] pick_gnt;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_valid;

  yadmc_rr_pick #(
    .NMasters (NMASTERS),
    .IdxW     (IdxW)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Up-counter equivalent of a down-counter loaded with trefi: the tick falls
  // where the down-count would read 1, and the reset value stays constant.
  assign tick      = (trefi_i != '0) && (tcnt_q == trefi_i - TREFI_W'(1));
  assign refr_done = (state_q == StRefresh) && done_i;

  always_comb begin
    pending_d = pending_q;
    if (tick && !refr_done) begin
      if (pending_q != PendMax) begin
        pending_d = pending_q + PendW'(1);
      end
    end else if (!tick && refr_done) begin
      pending_d = pending_q - PendW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt_q    <= '0;
      pending_q <= '0;
    end else begin
      tcnt_q    <= tick ? '0 : tcnt_q + TREFI_W'(1);
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      refresh_q <= 1'b0;
      ptr_q     <= '0;
      gidx_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pending_q == PendMax) begin
            refresh_q <= 1'b1;
            state_q   <= StRefresh;
          end else if (pick_valid) begin
            grant_q <= pick_gnt;
            gidx_q  <= pick_idx;
            state_q <= StGrant;
          end else if (pending_q != '0) begin
            refresh_q <= 1'b1;
            state_q   <= StRefresh;
          end
        end
        StGrant: begin
          if (done_i) begin
            grant_q <= '0;
            ptr_q   <= (gidx_q == IdxW'(NMASTERS - 1)) ? '0 : gidx_q + IdxW'(1);
            state_q <= StIdle;
          end
        end
        StRefresh: begin
          if (done_i) begin
            refresh_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant_o   = grant_q;
  assign refresh_o = refresh_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_yadmc_sched.sv
// Self-checking bench for yadmc_sched against a cycle-level behavioural model.
module tb_yadmc_sched;

  localparam int NM = 4;
  localparam int TW = 12;
  localparam int MP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [TW-1:0] trefi;
  logic [NM-1:0] req;
  logic [NM-1:0] grant;
  logic          refresh;
  logic          done;
  logic [2:0]    pending;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  yadmc_sched #(
    .NMASTERS     (NM),
    .TREFI_W      (TW),
    .MAX_POSTPONE (MP)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .trefi_i   (trefi),
    .req_i     (req),
    .grant_o   (grant),
    .refresh_o (refresh),
    .done_i    (done),
    .pending_o (pending)
  );

  // Model: who owns the sequencer, refreshes owed, and cycles since reset.
  int m_gidx;
  int m_ptr;
  int m_pending;
  int m_elapsed;
  bit m_refr;
  int busy_age;
  int lat;

  function automatic void model_reset();
    m_gidx    = -1;
    m_ptr     = 0;
    m_pending = 0;
    m_elapsed = 0;
    m_refr    = 0;
    busy_age  = 0;
  endfunction

  function automatic bit model_busy();
    return (m_gidx >= 0) || m_refr;
  endfunction

  // A tick lands on every trefi-th clock edge after reset.
  function automatic bit model_tick();
    return (trefi != 0) && (((m_elapsed + 1) % int'(trefi)) == 0);
  endfunction

  function automatic void model_advance();
    bit t;
    bit dec;
    t   = model_tick();
    dec = m_refr && done;
    if (m_gidx >= 0) begin
      if (done) begin
        m_ptr  = (m_gidx + 1) % NM;
        m_gidx = -1;
      end
    end else if (m_refr) begin
      if (done) m_refr = 0;
    end else if (m_pending == MP) begin
      m_refr = 1;
    end else if (req != 0) begin
      for (int i = 0; i < NM; i++) begin
        int j;
        j = (m_ptr + i) % NM;
        if (req[j] && m_gidx < 0) m_gidx = j;
      end
    end else if (m_pending > 0) begin
      m_refr = 1;
    end
    if (t && !dec && m_pending < MP) m_pending++;
    else if (!t && dec) m_pending--;
    m_elapsed++;
  endfunction

  function automatic logic [NM+3:0] model_outs();
    logic [NM-1:0] g;
    g = '0;
    if (m_gidx >= 0) g[m_gidx] = 1'b1;
    return {g, m_refr, 3'(m_pending)};
  endfunction

  function automatic logic auto_done();
    return model_busy() && (busy_age >= lat);
  endfunction

  task automatic advance();
    bit was_busy;
    was_busy = model_busy();
    model_advance();
    @(posedge clk);
    #1;
    if (model_busy() && was_busy) busy_age++;
    else busy_age = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    trefi = 12'd100;
    rst_n = 1'b0;
    req   = '1;
    done  = 1'b0;
    #1;
    checks++;
    if ({grant, refresh, pending} !== '0) begin
      failures++;
      $display("FAIL reset_async got=%b exp=0", {grant, refresh, pending});
    end
    do_reset();
    @(negedge clk);
    checks++;
    if ({grant, refresh, pending} !== model_outs()) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", {grant, refresh, pending}, model_outs());
    end
    advance();
  endtask

  task automatic test_refresh_basic();
    int pend_s = -1;
    int refr_s = -1;
    trefi = 12'd100;
    do_reset();
    for (int s = 0; s < 130; s++) begin
      done = (s == 109);
      @(negedge clk);
      checks++;
      if ({grant, refresh, pending} !== model_outs()) begin
        failures++;
        $display("FAIL refresh_basic s=%0d got=%b exp=%b", s, {grant, refresh, pending},
                 model_outs());
      end
      if (pending == 3'd1 && pend_s < 0) pend_s = s;
      if (refresh && refr_s < 0) refr_s = s;
      if (s == 110) begin
        checks++;
        if (refresh !== 1'b0 || pending !== 3'd0) begin
          failures++;
          $display("FAIL refresh_basic_done got refresh=%b pending=%0d exp 0/0", refresh, pending);
        end
      end
      advance();
    end
    checks++;
    if (pend_s != 100 || refr_s != 101) begin
      failures++;
      $display("FAIL refresh_basic_timing got pend=%0d refr=%0d exp 100/101", pend_s, refr_s);
    end
  endtask

  task automatic test_rotate();
    logic [NM-1:0] prev_g = '0;
    int n = 0;
    trefi = '0;
    lat   = 3;
    do_reset();
    req = '1;
    for (int s = 0; s < 30; s++) begin
      done = auto_done();
      @(negedge clk);
      checks++;
      if ({grant, refresh, pending} !== model_outs()) begin
        failures++;
        $display("FAIL rotate s=%0d got=%b exp=%b", s, {grant, refresh, pending}, model_outs());
      end
      if (grant != 0 && prev_g == 0 && n < 5) begin
        logic [NM-1:0] exp_g;
        exp_g = '0;
        exp_g[n % NM] = 1'b1;
        checks++;
        if (grant !== exp_g || s != 1 + 5 * n) begin
          failures++;
          $display("FAIL rotate_order n=%0d got=%b@%0d exp=%b@%0d", n, grant, s, exp_g, 1 + 5 * n);
        end
        n++;
      end
      prev_g = grant;
      advance();
    end
  endtask

  task automatic test_postpone();
    logic prev_r = 1'b0;
    logic [NM-1:0] prev_g = '0;
    bit seen_refr = 0;
    bit want_grant = 0;
    trefi = 12'd10;
    lat   = 3;
    do_reset();
    req = 4'b0100;
    for (int s = 0; s < 200; s++) begin
      done = auto_done();
      @(negedge clk);
      checks++;
      if ({grant, refresh, pending} !== model_outs()) begin
        failures++;
        $display("FAIL postpone s=%0d got=%b exp=%b", s, {grant, refresh, pending}, model_outs());
      end
      if (refresh && !prev_r && !seen_refr) begin
        seen_refr  = 1;
        want_grant = 1;
        checks++;
        if (pending !== 3'(MP) || s != 41) begin
          failures++;
          $display("FAIL postpone_forced got pending=%0d@%0d exp %0d@41", pending, s, MP);
        end
      end
      if (want_grant && grant != 0 && prev_g == 0) begin
        want_grant = 0;
        checks++;
        if (grant !== 4'b0100) begin
          failures++;
          $display("FAIL postpone_resume got=%b exp=0100", grant);
        end
      end
      prev_r = refresh;
      prev_g = grant;
      advance();
    end
  endtask

  task automatic test_coincident();
    int coinc = 0;
    bit chk_next = 0;
    logic [2:0] p_before = '0;
    trefi = 12'd10;
    do_reset();
    for (int s = 0; s < 120; s++) begin
      done = m_refr && model_tick();
      @(negedge clk);
      checks++;
      if ({grant, refresh, pending} !== model_outs() || (refresh && grant != 0)
          || !$onehot0(grant)) begin
        failures++;
        $display("FAIL coincident s=%0d got=%b exp=%b", s, {grant, refresh, pending},
                 model_outs());
      end
      if (chk_next) begin
        chk_next = 0;
        checks++;
        if (pending !== p_before) begin
          failures++;
          $display("FAIL coincident_net got=%0d exp=%0d", pending, p_before);
        end
      end
      if (done && refresh && model_tick()) begin
        coinc++;
        chk_next = 1;
        p_before = pending;
      end
      advance();
    end
    checks++;
    if (coinc < 3) begin
      failures++;
      $display("FAIL coincident_count got=%0d exp>=3", coinc);
    end
  endtask

  task automatic test_reset_mid();
    trefi = '0;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      req  = (s < 2) ? 4'b0001 : 4'b0010;
      done = (s == 1);
      @(negedge clk);
      checks++;
      if ({grant, refresh, pending} !== model_outs()) begin
        failures++;
        $display("FAIL reset_mid_pre s=%0d got=%b exp=%b", s, {grant, refresh, pending},
                 model_outs());
      end
      advance();
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL reset_mid_held got=%b exp=0010", grant);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, refresh, pending} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got=%b exp=0", {grant, refresh, pending});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    req  = 4'b0011;
    done = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++;
      if ({grant, refresh, pending} !== model_outs()) begin
        failures++;
        $display("FAIL reset_mid_post s=%0d got=%b exp=%b", s, {grant, refresh, pending},
                 model_outs());
      end
      if (s == 1) begin
        checks++;
        if (grant !== 4'b0001) begin
          failures++;
          $display("FAIL reset_mid_ptr got=%b exp=0001", grant);
        end
      end
      advance();
    end
  endtask

  task automatic test_trefi_zero();
    bit bad = 0;
    trefi = '0;
    do_reset();
    for (int s = 0; s < 5000; s++) begin
      @(negedge clk);
      if (refresh !== 1'b0 || pending !== 3'd0) bad = 1;
      advance();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL trefi_zero got refresh/pending activity exp none");
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      trefi = (it == 0) ? 12'd1 : TW'($urandom_range(0, 40));
      lat   = $urandom_range(0, 5);
      do_reset();
      for (int s = 0; s < 400; s++) begin
        if (model_busy()) done = (busy_age >= lat);
        else done = ($urandom_range(0, 9) == 0);
        @(negedge clk);
        checks++;
        if ({grant, refresh, pending} !== model_outs() || (refresh && grant != 0)
            || !$onehot0(grant)) begin
          failures++;
          $display("FAIL random it=%0d trefi=%0d s=%0d got=%b exp=%b", it, trefi, s,
                   {grant, refresh, pending}, model_outs());
        end
        advance();
        // Masters hold until granted, then may drop; idle masters may raise.
        for (int i = 0; i < NM; i++) begin
          if (m_gidx == i) req[i] = 1'($urandom_range(0, 1));
          else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    trefi = '0;
    req   = '0;
    done  = 1'b0;
    lat   = 0;
    model_reset();
    test_reset();
    test_refresh_basic();
    test_rotate();
    test_postpone();
    test_coincident();
    test_reset_mid();
    test_trefi_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/yadmc_sched.md
# yadmc_sched

Command scheduler for the dynamic memory controller. It shares the single SDRAM command sequencer between `NMASTERS` requesters using round-robin arbitration and interleaves periodic auto-refresh. Refreshes may be postponed while masters are busy, up to `MAX_POSTPONE`, after which a refresh is forced. The block sits in the controller clock domain, ahead of the command sequencer. Flags arriving from other domains reach it through the existing flag synchronizers.

## Interface
Parameters:
- `NMASTERS`, 4: number of requesters (2..8).
- `TREFI_W`, 12: width of the refresh interval counter.
- `MAX_POSTPONE`, 4: maximum number of outstanding refreshes (1..7).

Ports:
- `clk` input 1: controller clock. The block has a single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `trefi` input `TREFI_W`: refresh interval in clocks. It is static during operation. A value of 0 disables refresh.
- `req` input `NMASTERS`: per-master access request. A master holds its request until it is granted.
- `grant` output `NMASTERS`: one-hot grant. It is held high until `done`.
- `refresh` output 1: request to the sequencer to issue an auto-refresh. It is held high until `done`.
- `done` input 1: single-cycle pulse from the sequencer when the current access or refresh completes.
- `pending` output 3: number of outstanding refreshes.

## Operation
- Reset state: `grant`=0, `refresh`=0, `pending`=0. The FSM is in IDLE, the round-robin pointer is 0, and the timer is loaded with `trefi`.
- Refresh timer:
  - It decrements every clock.
  - At 1 it generates a tick and reloads `trefi`.
  - Each tick increments `pending`, saturating at `MAX_POSTPONE`.
  - If `trefi`=0, no ticks are generated.
- FSM states are IDLE, GRANT and REFRESH.
- IDLE, evaluated in priority order:
  1. If `pending`==`MAX_POSTPONE`, go to REFRESH (forced).
  2. Else if any `req` bit is set, grant the first requester at or after the pointer, wrapping, and go to GRANT.
  3. Else if `pending`>0, go to REFRESH (opportunistic).
  4. Else stay in IDLE.
- GRANT:
  - `grant` is held constant. Changes on `req` are ignored.
  - On `done`: clear `grant`, set the pointer to the granted index +1 (modulo `NMASTERS`), and go to IDLE.
- REFRESH:
  - `refresh` is held high.
  - On `done`: decrement `pending`, drop `refresh`, and go to IDLE.
- Tick and `done` in the same cycle while in REFRESH: `pending` is unchanged (net 0).
- Saturation: a tick with `pending`==`MAX_POSTPONE` is dropped. This is legal only if `trefi` is misconfigured.
- `done` received in IDLE is ignored.
- `grant` and `refresh` are never high together. At most one `grant` bit is set at any time.

## Timing
- All outputs are registered.
- A `req` sampled in IDLE at cycle t produces `grant` at t+1.
- `done` at cycle t drops `grant`/`refresh` at t+1 (FSM back in IDLE). The next `grant`/`refresh` can appear at t+2.
- Each operation costs 1 IDLE cycle. There is no back-to-back grant.
- A `pending` increment is visible the cycle after the tick.
- A forced refresh starts at most one operation after `pending` reaches `MAX_POSTPONE`.
- Reset asserted mid-operation clears all state immediately. A sequencer command in flight is abandoned, and the sequencer is reset by the same `rst_n`.

## Structure
- Shared package `yadmc_pkg` holds:
  - FSM state encoding (IDLE=2'd0, GRANT=2'd1, REFRESH=2'd2);
  - the `pending` width constant (3).
- Sub-module `yadmc_rr_pick`: a combinational round-robin picker. Inputs are `req` and the pointer. Outputs are the one-hot winner and its index.
- The timer, `pending` counter and FSM are in `yadmc_sched`.

## Test plan
- Reset, then `trefi`=100 with no `req` → `pending` reaches 1 at cycle 101. `refresh` rises at 102. `done` at 110 → `pending`=0 and `refresh`=0 at 111.
- All 4 `req` bits held, `done` returned 3 cycles after each grant → grants rotate 0,1,2,3,0 with 1 idle cycle between each.
- `trefi`=10, `MAX_POSTPONE`=4, `req`[2] continuously high → refresh deferred until `pending`=4. Then `refresh` is issued ahead of `req`[2]. After `done`, `grant`[2] resumes.
- Tick coincident with the refresh `done` → `pending` stays at its prior value. No grant/refresh overlap at any point.
- `rst_n` low while `grant`[1] is held → `grant`=0 immediately. After release, the pointer restarts at 0 and `req`=4'b0011 is granted to master 0.
- `trefi`=0 for 5000 cycles with no `req` → `refresh` never asserts and `pending` stays 0.
